// File: rtl/shared_mult_ctrl_pkg.sv
// shared_mult_ctrl_pkg: state encoding and default operand width for the shared multiplier
package shared_mult_ctrl_pkg;
    localparam int N_DEF = 4;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/shared_mult_ctrl_if.sv
// shared_mult_ctrl_if: request/grant/result bundle between two requesters and the shared multiplier
interface shared_mult_ctrl_if import shared_mult_ctrl_pkg::*; #(parameter int N = N_DEF);
    logic req0, req1;
    logic [N-1:0] a0, b0, a1, b1;
    logic gnt0, gnt1, busy, valid, id;
    logic [2*N-1:0] y;
    modport master (output req0, req1, a0, b0, a1, b1, input gnt0, gnt1, busy, y, valid, id);
    modport slave (input req0, req1, a0, b0, a1, b1, output gnt0, gnt1, busy, y, valid, id);
endinterface

// File: rtl/mult_shift_add_dp.sv
// mult_shift_add_dp: operand registers, 2N-bit accumulator and bit counter for LSB-first shift-add
module mult_shift_add_dp import shared_mult_ctrl_pkg::*; #(parameter int N = N_DEF) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] sum,
    output logic           last
);
    localparam int CW = N > 1 ? $clog2(N) : 1;
    logic [2*N-1:0] mcand, acc;
    logic [N-1:0] mplier;
    logic [CW-1:0] cnt;
    // mcand carries the multiplicand already shifted by the current bit index
    assign sum = acc + (mplier[0] ? mcand : '0);
    assign last = cnt == CW'(N - 1);
    always_ff @(posedge CLK) begin
        if (RST) begin
            mcand <= '0;
            mplier <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (load) begin
            mcand <= {{N{1'b0}}, a};
            mplier <= b;
            acc <= '0;
            cnt <= '0;
        end else if (step) begin
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            acc <= sum;
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/shared_mult_ctrl.sv
// shared_mult_ctrl: round-robin arbiter and FSM sharing one shift-add multiplier between two requesters
module shared_mult_ctrl import shared_mult_ctrl_pkg::*; #(parameter int N = N_DEF) (
    input  logic CLK,
    input  logic RST,
    shared_mult_ctrl_if.slave bus
);
    state_t state, nxt;
    logic last_srv, pick, load, step, last;
    logic [2*N-1:0] sum;
    // last_srv doubles as the winner of the operation in flight
    assign pick = bus.req0 & bus.req1 ? ~last_srv : bus.req1;
    assign bus.busy = state != IDLE;
    always_comb begin
        load = state == IDLE && (bus.req0 || bus.req1);
        step = state == CALC;
        nxt = load ? CALC : (step && last) ? DONE : (state == DONE) ? IDLE : state;
    end
    mult_shift_add_dp #(.N(N)) dp (
        .CLK(CLK),
        .RST(RST),
        .load(load),
        .step(step),
        .a(pick ? bus.a1 : bus.a0),
        .b(pick ? bus.b1 : bus.b0),
        .sum(sum),
        .last(last)
    );
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            last_srv <= 1'b1;
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            bus.valid <= 1'b0;
            bus.y <= '0;
            bus.id <= 1'b0;
        end else begin
            state <= nxt;
            bus.gnt0 <= load & ~pick;
            bus.gnt1 <= load & pick;
            bus.valid <= step & last;
            if (load) last_srv <= pick;
            if (step && last) begin
                bus.y <= sum;
                bus.id <= last_srv;
            end
        end
    end
endmodule

// File: doc/shared_mult_ctrl.md
SHARED_MULT_CTRL -- requirements
Module: shared_mult_ctrl

Interface
REQ-001 Parameter: N, default 4, operand width in bits; the product width is 2N.
REQ-002 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 REQ0, REQ1  in  1 each  multiply request from requester 0 and requester 1.
REQ-005 A0, B0, A1, B1  in  N each  multiplicand and multiplier of each requester; held stable while the matching REQ is high.
REQ-006 GNT0, GNT1  out  1 each  registered one-cycle pulse; the request was accepted and its operands were latched.
REQ-007 BUSY  out  1  high whenever the state is not IDLE.
REQ-008 Y  out  2N  registered product; holds its value between results.
REQ-009 VALID  out  1  one-cycle pulse; Y and ID carry a new result.
REQ-010 ID  out  1  requester index of the current result.

Function
REQ-011 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-012 In IDLE, a rising edge with at least one REQ high SHALL select a winner, latch its A and B, clear the 2N-bit accumulator and bit counter, pulse that GNT in the next cycle, and enter CALC.
REQ-013 Arbitration SHALL be round-robin: with both REQs high, the requester not served last wins; a single active REQ wins regardless of history.
REQ-014 REQ inputs SHALL be ignored in CALC and DONE; a requester drops REQ on seeing GNT, and REQ high at a later IDLE edge is a new request.
REQ-015 CALC SHALL run exactly N cycles, one multiplier bit per cycle, LSB first; when bit i is 1, the accumulator adds the multiplicand shifted left by i; the addition is 2N bits wide with no truncation.
REQ-016 On the edge that processes bit N-1, the FSM SHALL load Y with the final product, load ID with the winner, assert VALID and enter DONE.
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE, deasserting VALID.
REQ-018 Latency SHALL be fixed: VALID is high N cycles after the GNT cycle, for every operand value, including zero.
REQ-019 Throughput SHALL be one product per N+2 cycles; the earliest next acceptance is the IDLE edge after DONE.
REQ-020 Products SHALL be unsigned and exact: max (2^N-1)^2 = 225 for N=4.
REQ-021 Operand changes after acceptance SHALL NOT affect the result in progress.

Reset
REQ-022 RST SHALL override all other inputs at the clock edge.
REQ-023 On RST: state=IDLE; Y=0; VALID=0; GNT0=GNT1=0; ID=0; BUSY=0; accumulator and counter cleared; last-served pointer=1, so requester 0 wins the first tie.
REQ-024 RST during CALC or DONE SHALL abort the operation with no VALID pulse; the aborted request is not retried.

Structure
REQ-025 A shared package SHALL hold the state encoding constants (IDLE, CALC, DONE) and the default N.
REQ-026 The shift-add datapath (operand registers, accumulator, bit counter) SHALL be one sub-module, mult_shift_add_dp; shared_mult_ctrl holds the FSM and arbiter.

Verification
REQ-027 After reset, REQ0 with A0=3, B0=5 -> GNT0 pulses once; 4 cycles later VALID=1, Y=15, ID=0; BUSY falls one cycle after that.
REQ-028 REQ1 with A1=15, B1=15 -> Y=225, ID=1, with no overflow.
REQ-029 REQ0 and REQ1 both held high, A0=2, B0=3, A1=4, B1=5 -> grants alternate 0, 1, 0; results 6 (ID 0), 20 (ID 1), 6 (ID 0); 6 cycles between GNT pulses.
REQ-030 REQ0 with A0=0, B0=9 -> Y=0 with VALID at the same 4-cycle latency.
REQ-031 RST pulsed in the second CALC cycle -> no VALID, Y=0, BUSY=0 the next cycle; a following REQ1-only request (A1=6, B1=7) -> GNT1, Y=42.
REQ-032 REQ1 raised while CALC is serving requester 0 -> no GNT1 until the IDLE edge after DONE; then GNT1 pulses and the result is correct.
